// File: rtl/move_select_pkg.sv
// Shared chess constants for move_select and rank_material.
// Contents: piece encoding, signed material values, the default eval width,
// and the move_select state encoding.
// Piece encoding: bits [2:0] give the piece kind, and bit 3 set means a black piece.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 64
`endif

package move_select_pkg;

  localparam int unsigned PIECE_BITS_DEF    = `PIECE_BITS;
  localparam int unsigned MAX_POSITIONS_DEF = `MAX_POSITIONS;
  localparam int unsigned EVAL_WIDTH_DEF    = 16;
  localparam int unsigned BLACK_BIT         = 3;

  localparam logic [2:0] PIECE_EMPTY  = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  localparam logic signed [EVAL_WIDTH_DEF-1:0] VAL_PAWN   = EVAL_WIDTH_DEF'(100);
  localparam logic signed [EVAL_WIDTH_DEF-1:0] VAL_KNIGHT = EVAL_WIDTH_DEF'(320);
  localparam logic signed [EVAL_WIDTH_DEF-1:0] VAL_BISHOP = EVAL_WIDTH_DEF'(330);
  localparam logic signed [EVAL_WIDTH_DEF-1:0] VAL_ROOK   = EVAL_WIDTH_DEF'(500);
  localparam logic signed [EVAL_WIDTH_DEF-1:0] VAL_QUEEN  = EVAL_WIDTH_DEF'(900);
  localparam logic signed [EVAL_WIDTH_DEF-1:0] VAL_KING   = EVAL_WIDTH_DEF'(0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EVAL,
    ST_CMP,
    ST_CLEAR,
    ST_DONE
  } ms_state_e;

  // Unsigned material value of a piece kind; the caller applies the colour.
  function automatic logic signed [EVAL_WIDTH_DEF-1:0] piece_value(input logic [2:0] kind);
    case (kind)
      PIECE_PAWN:   piece_value = VAL_PAWN;
      PIECE_KNIGHT: piece_value = VAL_KNIGHT;
      PIECE_BISHOP: piece_value = VAL_BISHOP;
      PIECE_ROOK:   piece_value = VAL_ROOK;
      PIECE_QUEEN:  piece_value = VAL_QUEEN;
      PIECE_KING:   piece_value = VAL_KING;
      default:      piece_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/move_select_rank_material.sv
// rank_material: combinational material sum of one rank (8 squares).
// Ports:
//   rank       - SIDE_WIDTH bits; square f is at bits [f*PIECE_WIDTH +: PIECE_WIDTH]
//   rank_sum_c - signed sum; white pieces count positive, black pieces negative
module rank_material
  import move_select_pkg::*;
#(
  parameter int unsigned PIECE_WIDTH = PIECE_BITS_DEF,
  parameter int unsigned SIDE_WIDTH  = PIECE_WIDTH * 8,
  parameter int unsigned EVAL_WIDTH  = EVAL_WIDTH_DEF
) (
  input  logic [SIDE_WIDTH-1:0]        rank,
  output logic signed [EVAL_WIDTH-1:0] rank_sum_c
);

  logic [PIECE_WIDTH-1:0]        piece;
  logic signed [EVAL_WIDTH-1:0]  val;

  // Add or subtract each square's value according to its colour bit.
  always_comb begin
    rank_sum_c = '0;
    piece      = '0;
    val        = '0;
    for (int f = 0; f < 8; f++) begin
      piece = rank[f*PIECE_WIDTH +: PIECE_WIDTH];
      val   = EVAL_WIDTH'(piece_value(piece[2:0]));
      if (piece[BLACK_BIT])
        rank_sum_c = rank_sum_c - val;
      else
        rank_sum_c = rank_sum_c + val;
    end
  end

endmodule

// File: rtl/move_select.sv
// move_select: walks the all_moves list, scores every position by material
// and reports the best index for the side that just moved, then releases
// all_moves with a one-cycle clear_moves pulse.
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   moves_ready     - all_moves list valid (level)
//   move_count      - number of generated moves
//   board_in        - board at move_index, one-cycle read latency
//   maximize_white  - 1: choose max (white - black) score, 0: choose min
//   move_index      - read address into all_moves
//   clear_moves     - one-cycle release pulse to all_moves
//   result_valid    - one-cycle pulse, result fields valid
//   no_moves        - move_count was zero
//   best_index      - index of the best move
//   best_score      - signed score of the best move
// Optional: define MOVE_SELECT_TRACE_EN for simulation trace output.
module move_select
  import move_select_pkg::*;
#(
  parameter int unsigned PIECE_WIDTH        = PIECE_BITS_DEF,
  parameter int unsigned SIDE_WIDTH         = PIECE_WIDTH * 8,
  parameter int unsigned BOARD_WIDTH        = PIECE_WIDTH * 64,
  parameter int unsigned MAX_POSITIONS      = MAX_POSITIONS_DEF,
  parameter int unsigned MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
  parameter int unsigned EVAL_WIDTH         = EVAL_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
  input  logic [BOARD_WIDTH-1:0]        board_in,
  input  logic                          maximize_white,
  output logic [MAX_POSITIONS_LOG2-1:0] move_index,
  output logic                          clear_moves,
  output logic                          result_valid,
  output logic                          no_moves,
  output logic [MAX_POSITIONS_LOG2-1:0] best_index,
  output logic signed [EVAL_WIDTH-1:0]  best_score
);

  localparam int unsigned IW = MAX_POSITIONS_LOG2 + 1;

  ms_state_e                     state_q, state_d;
  logic [MAX_POSITIONS_LOG2-1:0] count_q, count_d;
  logic                          max_q, max_d;
  logic signed [EVAL_WIDTH-1:0]  acc_q, acc_d;
  logic [2:0]                    rank_q, rank_d;
  logic [MAX_POSITIONS_LOG2-1:0] idx_d, best_idx_d;
  logic signed [EVAL_WIDTH-1:0]  best_score_d;
  logic                          no_moves_d, clear_d, valid_d;
  logic                          better_c, upd_c;
  logic [SIDE_WIDTH-1:0]         rank_bits_c;
  logic signed [EVAL_WIDTH-1:0]  rank_sum_c;

  assign rank_bits_c = board_in[rank_q*SIDE_WIDTH +: SIDE_WIDTH];

  rank_material #(
    .PIECE_WIDTH (PIECE_WIDTH),
    .SIDE_WIDTH  (SIDE_WIDTH),
    .EVAL_WIDTH  (EVAL_WIDTH)
  ) u_rank_material (
    .rank       (rank_bits_c),
    .rank_sum_c (rank_sum_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    max_d        = max_q;
    acc_d        = acc_q;
    rank_d       = rank_q;
    idx_d        = move_index;
    best_idx_d   = best_index;
    best_score_d = best_score;
    no_moves_d   = no_moves;
    clear_d      = 1'b0;
    valid_d      = 1'b0;
    better_c     = max_q ? (acc_q > best_score) : (acc_q < best_score);
    upd_c        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (moves_ready) begin
          count_d      = move_count;
          max_d        = maximize_white;
          best_idx_d   = '0;
          best_score_d = '0;
          if (move_count != '0) begin
            no_moves_d = 1'b0;
            state_d    = ST_FETCH;
          end else begin
            no_moves_d = 1'b1;
            clear_d    = 1'b1;
            state_d    = ST_CLEAR;
          end
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        acc_d   = '0;
        rank_d  = '0;
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        acc_d  = acc_q + rank_sum_c;
        rank_d = rank_q + 3'd1;
        if (rank_q == 3'd7)
          state_d = ST_CMP;
      end
      ST_CMP: begin
        // Strict comparison: ties keep the earlier index.
        if (move_index == '0 || better_c) begin
          upd_c        = 1'b1;
          best_idx_d   = move_index;
          best_score_d = acc_q;
        end
        if ((IW'(move_index) + IW'(1)) < IW'(count_q)) begin
          idx_d   = move_index + MAX_POSITIONS_LOG2'(1);
          state_d = ST_FETCH;
        end else begin
          clear_d = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        valid_d = 1'b1;
        state_d = ST_DONE;
      end
      // DONE doubles as all_moves' reset cycle, so moves_ready is stale here.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      max_q        <= 1'b0;
      acc_q        <= '0;
      rank_q       <= '0;
      move_index   <= '0;
      best_index   <= '0;
      best_score   <= '0;
      no_moves     <= 1'b0;
      clear_moves  <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      max_q        <= max_d;
      acc_q        <= acc_d;
      rank_q       <= rank_d;
      move_index   <= idx_d;
      best_index   <= best_idx_d;
      best_score   <= best_score_d;
      no_moves     <= no_moves_d;
      clear_moves  <= clear_d;
      result_valid <= valid_d;
    end
  end

`ifdef MOVE_SELECT_TRACE_EN
  // Simulation trace of each comparison and each final result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CMP)
        $display("move_select: index=%0d score=%0d updated=%0b", move_index, acc_q, upd_c);
      if (state_q == ST_DONE)
        $display("move_select: best_index=%0d best_score=%0d no_moves=%0b",
                 best_index, best_score, no_moves);
    end
  end
`endif

endmodule

// File: doc/move_select.md
Name: move_select

Overview:
- Synthesizable consumer of the all_moves output.
- Once the move list is ready, walks every generated position, scores each by material, and records the best index for the side that just moved.
- Then pulses clear_moves so all_moves can accept the next board.
- Replaces the bench-only move-walk state machine; sits directly downstream of all_moves, with port names matching all_moves connections.

Parameters:
- PIECE_WIDTH, `PIECE_BITS, bits per square
- SIDE_WIDTH, PIECE_WIDTH*8, bits per rank
- BOARD_WIDTH, PIECE_WIDTH*64, bits per board
- MAX_POSITIONS, `MAX_POSITIONS, move list depth
- MAX_POSITIONS_LOG2, $clog2(`MAX_POSITIONS), index width
- EVAL_WIDTH, 16, signed score width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- moves_ready  in  1  all_moves list valid (level)
- move_count  in  MAX_POSITIONS_LOG2  number of generated moves
- board_in  in  BOARD_WIDTH  all_moves board_out for current move_index; 1-cycle read latency
- maximize_white  in  1  1 = pick max white-minus-black score, 0 = pick min; sampled at start
- move_index  out  MAX_POSITIONS_LOG2  read address into all_moves
- clear_moves  out  1  one-cycle pulse releasing all_moves
- result_valid  out  1  one-cycle pulse, result fields valid
- no_moves  out  1  move_count was 0 (mate/stalemate)
- best_index  out  MAX_POSITIONS_LOG2  index of best move
- best_score  out  EVAL_WIDTH  signed score of best move (white minus black)

Behaviour:
- Clocking and reset:
  - One clock domain, clk only.
  - Reset is synchronous, active-high.
  - Reset clears all outputs to 0 and sets state to IDLE.
  - Reset mid-walk abandons the walk, issues no clear_moves and no result_valid.
- Piece values (signed): pawn 100, knight 320, bishop 330, rook 500, queen 900, king 0, empty 0. White positive, black negative.
- Score: sum of all 64 squares, accumulated one rank per cycle. Each rank sum is 8 terms, added to a signed EVAL_WIDTH accumulator. Maximum magnitude fits in 16 bits, so no saturation logic.
- States:
  - IDLE: move_index=0. If moves_ready=1, latch move_count and maximize_white, then go to FETCH if count>0, else CLEAR with no_moves set.
  - FETCH: drive move_index; go to WAIT.
  - WAIT: 1 cycle for RAM latency; accumulator=0, rank=0.
  - EVAL: 8 cycles, ranks 0..7 summed from board_in; go to CMP after rank 7.
  - CMP:
    - If index==0, or score strictly better than best_score (greater when maximizing, less otherwise), update best_index and best_score.
    - Ties keep the lower index.
    - Then index+1 < count → FETCH, else CLEAR.
  - CLEAR: clear_moves=1 for exactly one cycle.
  - DONE: result_valid=1 for one cycle; go to IDLE.
- Timing:
  - 11 cycles per move.
  - For N>0 moves, result_valid occurs 11N+2 cycles after the IDLE cycle that sampled moves_ready.
  - For N=0, result_valid occurs 2 cycles after that IDLE cycle.
- The DONE cycle gives all_moves its reset cycle. IDLE must not re-trigger on a stale moves_ready; all_moves drops moves_ready one cycle after clear_moves.
- best_index, best_score and no_moves hold until the next accepted start; no_moves is cleared at the start.
- moves_ready deasserting mid-walk is ignored.
- move_count is latched, so changes after start have no effect.

Optional Feature:
- Macro MOVE_SELECT_TRACE_EN, simulation only.
- Defined: in CMP, $display index, score, and whether best was updated; in DONE, $display best_index/best_score/no_moves.
- Undefined: no display code compiled in. Cycle behaviour is identical either way.

Decomposition:
- Shared package (vchess_pkg or vchess.vh):
  - piece value constants VAL_PAWN..VAL_KING
  - EVAL_WIDTH default
  - state encodings for move_select
- Sub-module rank_material: combinational, one SIDE_WIDTH rank in, signed EVAL_WIDTH sum out. Shared with the future evaluator.

Test Plan:
1. Initial position, white to move, maximize_white=1, 20 moves: all scores 0 → best_index=0, best_score=0, no_moves=0. clear_moves pulses once; result_valid occurs 222 cycles after start.
2. Board where move 5 captures a black queen (other moves score 0) → best_index=5, best_score=900.
3. maximize_white=0 with move 3 scoring -500, move 7 scoring -500, all others 0 → best_index=3 (tie keeps lower), best_score=-500.
4. move_count=0 with moves_ready=1 → no_moves=1, clear_moves pulse, result_valid 2 cycles after start, best_index=0.
5. Reset asserted during EVAL of move 4 → all outputs 0 next cycle, no clear_moves or result_valid. After reset, a fresh start on the same list yields the correct result.
6. Back-to-back runs, second board with 1 move scoring +100 → second result best_index=0, best_score=100, no_moves=0. Each run issues exactly one clear_moves.
